// File: rtl/pixel_stream_fifo.sv
// pixel_stream_fifo
// Tags each accepted RGB pixel with its raster position flags (start of
// frame, end of line, end of frame) inside a WIDTH x HEIGHT frame and
// buffers it in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   frame_restart           next accepted pixel is forced to raster (0,0)
//   in_valid / in_ready     upstream handshake (in_ready is registered)
//   inred/ingreen/inblue    incoming 8-bit colour components
//   out_valid / out_ready   downstream handshake (out_valid is registered)
//   outred/outgreen/outblue head pixel colour, zero while out_valid=0
//   out_sof/out_eol/out_eof head pixel raster flags, zero while out_valid=0
//   level                   current FIFO occupancy
module pixel_stream_fifo #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_restart,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 inred,
    input  logic [7:0]                 ingreen,
    input  logic [7:0]                 inblue,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 outred,
    output logic [7:0]                 outgreen,
    output logic [7:0]                 outblue,
    output logic                       out_sof,
    output logic                       out_eol,
    output logic                       out_eof,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int EW = 27;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

    // Entry layout: {sof, eol, eof, red, green, blue}
    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [EW-1:0] head_r;

    logic          push_s;
    logic          pop_s;
    logic [XW-1:0] base_x_s;
    logic [YW-1:0] base_y_s;
    logic          sof_s;
    logic          eol_s;
    logic          eof_s;
    logic [EW-1:0] entry_s;
    logic [LW-1:0] level_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [EW-1:0] head_next_s;
    logic [XW-1:0] x_next_s;
    logic [YW-1:0] y_next_s;

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    // Raster position seen by the pixel being pushed; a restart overrides it.
    always_comb begin
        base_x_s = x_r;
        base_y_s = y_r;
        if (frame_restart) begin
            base_x_s = {XW{1'b0}};
            base_y_s = {YW{1'b0}};
        end else begin
            base_x_s = x_r;
            base_y_s = y_r;
        end
    end

    assign sof_s   = (base_x_s == {XW{1'b0}}) && (base_y_s == {YW{1'b0}});
    assign eol_s   = (base_x_s == X_LAST);
    assign eof_s   = eol_s && (base_y_s == Y_LAST);
    assign entry_s = {sof_s, eol_s, eof_s, inred, ingreen, inblue};

    // Next raster position: advance on push, clear on a restart without push.
    always_comb begin
        x_next_s = x_r;
        y_next_s = y_r;
        if (push_s) begin
            if (eol_s) begin
                x_next_s = {XW{1'b0}};
                if (base_y_s == Y_LAST) begin
                    y_next_s = {YW{1'b0}};
                end else begin
                    y_next_s = base_y_s + YW'(1);
                end
            end else begin
                x_next_s = base_x_s + XW'(1);
                y_next_s = base_y_s;
            end
        end else if (frame_restart) begin
            x_next_s = {XW{1'b0}};
            y_next_s = {YW{1'b0}};
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
        end
    end

    // Occupancy after this edge.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    assign rd_ptr_next_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;

    // Next head register contents. When the slot being written this edge is
    // the next head slot (empty FIFO, or a single entry being popped) the
    // memory does not hold it yet, so the incoming entry is taken directly.
    always_comb begin
        head_next_s = {EW{1'b0}};
        if (level_next_s == {LW{1'b0}}) begin
            head_next_s = {EW{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = entry_s;
        end else begin
            head_next_s = mem[rd_ptr_next_s];
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem[wr_ptr_r] <= entry_s;
        end
    end

    // Control state, raster counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            level_r     <= {LW{1'b0}};
            x_r         <= {XW{1'b0}};
            y_r         <= {YW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            head_r      <= {EW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            x_r         <= x_next_s;
            y_r         <= y_next_s;
            in_ready_r  <= (level_next_s != L_FULL);
            out_valid_r <= (level_next_s != {LW{1'b0}});
            head_r      <= head_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign out_sof   = head_r[26];
    assign out_eol   = head_r[25];
    assign out_eof   = head_r[24];
    assign outred    = head_r[23:16];
    assign outgreen  = head_r[15:8];
    assign outblue   = head_r[7:0];

endmodule

// File: tb/tb_pixel_stream_fifo.sv
module tb_pixel_stream_fifo;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_restart = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] inred = 8'd0;
    logic [7:0] ingreen = 8'd0;
    logic [7:0] inblue = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] outred;
    logic [7:0] outgreen;
    logic [7:0] outblue;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    logic [3:0] level;

    int vectors = 0;
    int miscompares = 0;

    pixel_stream_fifo #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .frame_restart(frame_restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .inred(inred), .ingreen(ingreen), .inblue(inblue),
        .out_valid(out_valid), .out_ready(out_ready),
        .outred(outred), .outgreen(outgreen), .outblue(outblue),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .level(level)
    );

    always #5 clk = ~clk;

    // Reference model: queue of {sof,eol,eof,r,g,b} and linear raster index.
    logic [26:0] m_q [$];
    int          m_pos = 0;
    bit          m_rst_prev = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic rst, input logic fr, input logic iv, input logic ordy,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit          push;
        bit          pop;
        int          base;
        bit          sof;
        bit          eol;
        bit          eof;
        logic [26:0] head;
        logic [26:0] act;
        reset = rst; frame_restart = fr; in_valid = iv; out_ready = ordy;
        inred = r; ingreen = g; inblue = b;
        push = iv && !m_rst_prev && (m_q.size() != D);
        pop  = ordy && (m_q.size() != 0);
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_pos = 0;
            m_rst_prev = 1'b1;
        end else begin
            m_rst_prev = 1'b0;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                base = fr ? 0 : m_pos;
                sof  = (base == 0);
                eol  = ((base % W) == W - 1);
                eof  = eol && ((base / W) == H - 1);
                m_q.push_back({sof, eol, eof, r, g, b});
                m_pos = (base + 1) % (W * H);
            end else if (fr) begin
                m_pos = 0;
            end
        end
        #1;
        head = (m_q.size() != 0) ? m_q[0] : 27'd0;
        act  = {out_sof, out_eol, out_eof, outred, outgreen, outblue};
        chk("model_in_ready", int'(in_ready), int'(!m_rst_prev && (m_q.size() != D)));
        chk("model_out_valid", int'(out_valid), int'(m_q.size() != 0));
        chk("model_level", int'(level), m_q.size());
        chk("model_head", int'(act), int'(head));
    endtask

    typedef struct {
        logic       rst, fr, iv, ordy;
        logic [7:0] r;
        logic       e_valid, e_ready;
        int         e_level;
        logic [7:0] e_red;
        logic       e_sof, e_eol, e_eof;
    } vec_t;

    vec_t tbl [16];

    task automatic row(input int i, input logic rst, input logic fr, input logic iv,
                       input logic ordy, input logic [7:0] r, input logic ev, input logic er,
                       input int el, input logic [7:0] ered, input logic es,
                       input logic eeol, input logic eeof);
        tbl[i].rst = rst; tbl[i].fr = fr; tbl[i].iv = iv; tbl[i].ordy = ordy; tbl[i].r = r;
        tbl[i].e_valid = ev; tbl[i].e_ready = er; tbl[i].e_level = el; tbl[i].e_red = ered;
        tbl[i].e_sof = es; tbl[i].e_eol = eeol; tbl[i].e_eof = eeof;
    endtask

    initial begin
        // Reset for three cycles, release, single pixel, then a full frame of 8 plus one.
        for (int i = 0; i < 3; i++) row(i, 1, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);
        row(3, 0, 0, 0, 1, 8'd0, 0, 1, 0, 8'd0, 0, 0, 0);
        row(4, 0, 0, 1, 1, 8'd10, 1, 1, 1, 8'd10, 1, 0, 0);
        row(5, 0, 0, 0, 1, 8'd0, 0, 1, 0, 8'd0, 0, 0, 0);
        for (int p = 1; p <= 9; p++)
            row(5 + p, 0, (p == 1), 1, 1, 8'(p), 1, 1, 1, 8'(p),
                (p == 1 || p == 9), (p == 4 || p == 8), (p == 8));
        row(15, 0, 0, 0, 1, 8'd0, 0, 1, 0, 8'd0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] gg;
            logic [7:0] bb;
            gg = (i == 4) ? 8'd20 : 8'(tbl[i].r + 8'd100);
            bb = (i == 4) ? 8'd30 : 8'(tbl[i].r + 8'd200);
            step(tbl[i].rst, tbl[i].fr, tbl[i].iv, tbl[i].ordy, tbl[i].r, gg, bb);
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ready", i), int'(in_ready), int'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].e_level);
            chk($sformatf("tbl%0d_red", i), int'(outred), int'(tbl[i].e_red));
            chk($sformatf("tbl%0d_flags", i), int'({out_sof, out_eol, out_eof}),
                int'({tbl[i].e_sof, tbl[i].e_eol, tbl[i].e_eof}));
            if (i == 4) begin
                chk("tbl4_green", int'(outgreen), 20);
                chk("tbl4_blue", int'(outblue), 30);
            end
        end

        // Fill to full with the consumer stalled; ninth pixel must be held.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'(50 + i), 8'd1, 8'd2);
        chk("full_level", int'(level), 8);
        chk("full_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0, 8'd58, 8'd1, 8'd2);
            chk("full_hold_level", int'(level), 8);
        end
        step(0, 0, 1, 1, 8'd58, 8'd1, 8'd2);
        chk("full_pop_level", int'(level), 7);
        chk("full_pop_in_ready", int'(in_ready), 1);
        chk("full_pop_head", int'(outred), 51);
        step(0, 0, 1, 0, 8'd58, 8'd1, 8'd2);
        chk("ninth_level", int'(level), 8);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 8'd0, 8'd0, 8'd0);
        chk("drain_last_head", int'(outred), 58);
        chk("drain_last_level", int'(level), 1);
        step(0, 0, 0, 1, 8'd0, 8'd0, 8'd0);
        chk("drain_empty", int'(out_valid), 0);

        // Restart on the third pixel of a line.
        step(1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
        step(0, 0, 0, 1, 8'd0, 8'd0, 8'd0);
        step(0, 0, 1, 1, 8'd1, 8'd0, 8'd0);
        step(0, 0, 1, 1, 8'd2, 8'd0, 8'd0);
        step(0, 1, 1, 1, 8'd3, 8'd0, 8'd0);
        chk("restart_sof", int'(out_sof), 1);
        chk("restart_eol", int'(out_eol), 0);
        for (int p = 4; p <= 6; p++) begin
            step(0, 0, 1, 1, 8'(p), 8'd0, 8'd0);
            chk($sformatf("restart_p%0d_eol", p), int'(out_eol), int'(p == 6));
            chk($sformatf("restart_p%0d_sof", p), int'(out_sof), 0);
        end
        step(0, 0, 0, 1, 8'd0, 8'd0, 8'd0);

        // Level 3 with simultaneous push and pop for five cycles.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'(70 + i), 8'd5, 8'd6);
        chk("pp_fill_level", int'(level), 3);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] exp_red;
            step(0, 0, 1, 1, 8'(80 + i), 8'd5, 8'd6);
            exp_red = (i < 2) ? 8'(71 + i) : 8'(78 + i);
            chk($sformatf("pp%0d_level", i), int'(level), 3);
            chk($sformatf("pp%0d_head", i), int'(outred), int'(exp_red));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'd0, 8'd0, 8'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 ($urandom % 4) != 0, ($urandom % 3) != 0,
                 8'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
